// File: rtl/assoc_set.sv
// N-way set-associative cache set with true-LRU ages and victim selection.
// One op per cycle; response registered and flagged by a one-cycle ack.

module assoc_set_way #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 16,
  parameter int WORD_W = 2,
  parameter int WAY_W  = 2,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic              store,
  input  logic              touch_en,
  input  logic              touched,
  input  logic [WAY_W-1:0]  touch_age,
  input  logic [WORD_W-1:0] word,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [TAG_W-1:0]  tag_q,
  output logic              valid_q,
  output logic              dirty_q,
  output logic [DATA_W-1:0] word_q,
  output logic [WAY_W-1:0]  age_q,
  output logic              match
);
  logic [(1<<WORD_W)-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      age_q   <= WAY_W'(IDX);
    end else begin
      if (fill) begin
        tag_q   <= tag;
        valid_q <= valid_in;
        dirty_q <= 1'b0;
      end else if (store) begin
        dirty_q <= 1'b1;
      end
      // Ages younger than the touched way slide back by one; keeps a permutation.
      if (touch_en) begin
        if (touched)                age_q <= '0;
        else if (age_q < touch_age) age_q <= age_q + 1'b1;
      end
    end
  end

  // Line data is not reset.
  always_ff @(posedge clk) begin
    if (!rst && (fill || store)) mem[word] <= data_in;
  end

  assign word_q = mem[word];
  assign match  = valid_q && (tag_q == tag);
endmodule

module assoc_set #(
  parameter int  WAYS   = 4,
  parameter int  TAG_W  = 5,
  parameter int  DATA_W = 16,
  parameter int  WORD_W = 2,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cmp,
  input  logic              write,
  input  logic [WORD_W-1:0] word,
  input  logic [WAY_W-1:0]  way_in,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              hit,
  output logic              dirty,
  output logic              valid,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic [WAY_W-1:0]  way_out,
  output logic              ack
);
  localparam int STAGES = 1;

  logic [WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [WAYS-1:0][DATA_W-1:0] word_q;
  logic [WAYS-1:0][WAY_W-1:0]  age_q;
  logic [WAYS-1:0]             valid_q, dirty_q, match;
  logic [STAGES-1:0]           vld_pipe;

  logic             acc, hit_any, has_inv, do_fill, do_store, touch_en;
  logic [WAY_W-1:0] hit_idx, inv_idx, lru_idx, victim, rpt_way, touch_way, touch_age;

  assign acc = enable && !rst;

  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    lru_idx = '0;
    has_inv = 1'b0;
    // Descending scans so the lowest index wins.
    for (int i = WAYS-1; i >= 0; i--) begin
      if (match[i])                          hit_idx = WAY_W'(i);
      if (!valid_q[i]) begin
        inv_idx = WAY_W'(i);
        has_inv = 1'b1;
      end
      if (age_q[i] == WAY_W'(WAYS-1))        lru_idx = WAY_W'(i);
    end
    hit_any   = |match;
    victim    = has_inv ? inv_idx : lru_idx;
    rpt_way   = cmp ? (hit_any ? hit_idx : victim) : way_in;
    do_fill   = acc && !cmp && write;
    do_store  = acc && cmp && write && hit_any;
    touch_en  = acc && (cmp ? hit_any : write);
    touch_way = cmp ? hit_idx : way_in;
    touch_age = age_q[touch_way];
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    assoc_set_way #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .WORD_W(WORD_W), .WAY_W(WAY_W), .IDX(i)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .fill     (do_fill && (way_in == WAY_W'(i))),
      .store    (do_store && (hit_idx == WAY_W'(i))),
      .touch_en (touch_en),
      .touched  (touch_way == WAY_W'(i)),
      .touch_age(touch_age),
      .word     (word),
      .tag      (tag),
      .data_in  (data_in),
      .valid_in (valid_in),
      .tag_q    (tag_q[i]),
      .valid_q  (valid_q[i]),
      .dirty_q  (dirty_q[i]),
      .word_q   (word_q[i]),
      .age_q    (age_q[i]),
      .match    (match[i])
    );
  end

  // Writes report the line as it stands after the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      hit      <= 1'b0;
      dirty    <= 1'b0;
      valid    <= 1'b0;
      tag_out  <= '0;
      data_out <= '0;
      way_out  <= '0;
    end else begin
      vld_pipe <= STAGES'(acc);
      if (acc) begin
        hit     <= cmp && hit_any;
        way_out <= rpt_way;
        if (do_fill) begin
          tag_out  <= tag;
          valid    <= valid_in;
          dirty    <= 1'b0;
          data_out <= data_in;
        end else begin
          tag_out  <= tag_q[rpt_way];
          valid    <= valid_q[rpt_way];
          dirty    <= dirty_q[rpt_way] || do_store;
          data_out <= do_store ? data_in : word_q[rpt_way];
        end
      end
    end
  end

  assign ack = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_assoc_set.sv
// Directed bench for assoc_set: expected responses queued at drive time,
// popped and checked when the response cycle arrives.

module tb_assoc_set;
  logic        clk = 1'b0;
  logic        rst, enable, cmp, write, valid_in;
  logic [1:0]  word, way_in;
  logic [4:0]  tag;
  logic [15:0] data_in;
  logic        hit, dirty, valid, ack;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic [1:0]  way_out;

  assoc_set dut (
    .clk(clk), .rst(rst), .enable(enable), .cmp(cmp), .write(write),
    .word(word), .way_in(way_in), .tag(tag), .data_in(data_in),
    .valid_in(valid_in), .hit(hit), .dirty(dirty), .valid(valid),
    .tag_out(tag_out), .data_out(data_out), .way_out(way_out), .ack(ack)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] M_HIT = 6'd1, M_DRT = 6'd2, M_VLD = 6'd4,
                         M_TAG = 6'd8, M_DAT = 6'd16, M_WAY = 6'd32;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic        hit, dirty, valid;
    logic [4:0]  tag;
    logic [15:0] data;
    logic [1:0]  way;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic pending  = 1'b0;

  task automatic chk(input string nm, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [1:0] wd, input logic [1:0] wy,
                       input logic [4:0] tg, input logic [15:0] d, input logic vi);
    enable = 1'b1; cmp = c; write = w; word = wd; way_in = wy;
    tag = tg; data_in = d; valid_in = vi;
  endtask

  task automatic expect_rsp(input string nm, input logic [5:0] m, input logic h, input logic dt,
                            input logic v, input logic [4:0] tg, input logic [15:0] d,
                            input logic [1:0] wy);
    exp_t e;
    e.name = nm; e.mask = m; e.hit = h; e.dirty = dt; e.valid = v;
    e.tag = tg; e.data = d; e.way = wy;
    q.push_back(e);
    pending = 1'b1;
  endtask

  task automatic idle();
    enable = 1'b0;
  endtask

  // Advance one cycle, sample after the edge, check ack and any due response.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    chk("ack", {15'd0, ack}, {15'd0, pending});
    if (pending && q.size() > 0) begin
      e = q.pop_front();
      if (e.mask & M_HIT) chk({e.name, ".hit"},   {15'd0, hit},   {15'd0, e.hit});
      if (e.mask & M_DRT) chk({e.name, ".dirty"}, {15'd0, dirty}, {15'd0, e.dirty});
      if (e.mask & M_VLD) chk({e.name, ".valid"}, {15'd0, valid}, {15'd0, e.valid});
      if (e.mask & M_TAG) chk({e.name, ".tag"},   {11'd0, tag_out}, {11'd0, e.tag});
      if (e.mask & M_DAT) chk({e.name, ".data"},  data_out, e.data);
      if (e.mask & M_WAY) chk({e.name, ".way"},   {14'd0, way_out}, {14'd0, e.way});
    end
    pending = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".ack"},   {15'd0, ack},   16'd0);
    chk({nm, ".hit"},   {15'd0, hit},   16'd0);
    chk({nm, ".dirty"}, {15'd0, dirty}, 16'd0);
    chk({nm, ".valid"}, {15'd0, valid}, 16'd0);
    chk({nm, ".tag"},   {11'd0, tag_out}, 16'd0);
    chk({nm, ".data"},  data_out, 16'd0);
    chk({nm, ".way"},   {14'd0, way_out}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cmp = 1'b0; write = 1'b0; word = '0; way_in = '0;
    tag = '0; data_in = '0; valid_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_zero("reset");
    rst = 1'b0;

    // Cold miss: all invalid, victim is way 0
    drive(1, 0, 2'd3, 2'd0, 5'b11101, 16'h0, 0);
    expect_rsp("cold_miss", M_HIT|M_VLD|M_WAY|M_DRT, 0, 0, 0, 0, 0, 2'd0);
    step();

    drive(0, 1, 2'd3, 2'd0, 5'b11101, 16'h0F0F, 1);
    expect_rsp("acc_wr", M_HIT|M_DAT|M_WAY, 0, 0, 0, 0, 16'h0F0F, 2'd0);
    step(); idle(); step();

    drive(1, 0, 2'd3, 2'd0, 5'b11101, 16'h0, 0);
    expect_rsp("cmp_rd_hit", M_HIT|M_DAT|M_DRT|M_WAY, 1, 0, 0, 0, 16'h0F0F, 2'd0);
    step();

    drive(1, 1, 2'd3, 2'd0, 5'b11101, 16'hA5A5, 0);
    expect_rsp("cmp_wr_hit", M_HIT|M_DAT|M_WAY, 1, 0, 0, 0, 16'hA5A5, 2'd0);
    step();

    drive(1, 0, 2'd3, 2'd0, 5'b11101, 16'h0, 0);
    expect_rsp("rd_after_wr", M_HIT|M_DAT|M_DRT, 1, 1, 0, 0, 16'hA5A5, 2'd0);
    step();

    // Fill all four ways: ages end as way3 youngest, way0 oldest
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'd0, 2'(i), 5'(i + 1), 16'h1000 + 16'(i), 1);
      expect_rsp("fill", M_HIT|M_WAY|M_VLD|M_TAG, 0, 0, 1, 5'(i + 1), 0, 2'(i));
      step();
    end

    // Touching way0 makes way1 the oldest
    drive(1, 0, 2'd0, 2'd0, 5'd1, 16'h0, 0);
    expect_rsp("hit_t1", M_HIT|M_WAY|M_DAT|M_DRT, 1, 0, 0, 0, 16'h1000, 2'd0);
    step();

    drive(1, 0, 2'd0, 2'd0, 5'd9, 16'h0, 0);
    expect_rsp("lru_victim", M_HIT|M_WAY|M_TAG|M_VLD|M_DRT|M_DAT, 0, 0, 1, 5'd2, 16'h1001, 2'd1);
    step();

    // Miss must not disturb LRU: victim stays way1
    drive(1, 1, 2'd0, 2'd0, 5'd9, 16'hFFFF, 0);
    expect_rsp("miss_wr", M_HIT|M_WAY|M_TAG|M_DAT, 0, 0, 0, 5'd2, 16'h1001, 2'd1);
    step();

    drive(1, 1, 2'd0, 2'd0, 5'd1, 16'hBEEF, 0);
    expect_rsp("dirty_way0", M_HIT|M_WAY, 1, 0, 0, 0, 0, 2'd0);
    step();

    // Reset wins over a simultaneous op
    drive(1, 0, 2'd0, 2'd0, 5'd1, 16'h0, 0);
    rst = 1'b1;
    step();
    check_zero("rst_en");
    rst = 1'b0;

    drive(1, 0, 2'd3, 2'd0, 5'b11101, 16'h0, 0);
    expect_rsp("post_rst", M_HIT|M_VLD|M_WAY|M_DRT, 0, 0, 0, 0, 0, 2'd0);
    step();

    // Back-to-back: enable stays high across three ops
    drive(0, 1, 2'd1, 2'd2, 5'd7, 16'h1234, 1);
    expect_rsp("b2b_fill", M_HIT|M_DAT|M_WAY, 0, 0, 0, 0, 16'h1234, 2'd2);
    step();
    drive(1, 0, 2'd1, 2'd0, 5'd7, 16'h0, 0);
    expect_rsp("b2b_rd", M_HIT|M_DAT|M_WAY|M_DRT, 1, 0, 0, 0, 16'h1234, 2'd2);
    step();
    drive(1, 1, 2'd1, 2'd0, 5'd7, 16'h5678, 0);
    expect_rsp("b2b_wr", M_HIT|M_DAT|M_WAY, 1, 0, 0, 0, 16'h5678, 2'd2);
    step();
    idle();
    step();

    drive(0, 0, 2'd1, 2'd2, 5'd0, 16'h0, 0);
    expect_rsp("acc_rd", M_HIT|M_DAT|M_WAY|M_DRT|M_VLD|M_TAG, 0, 1, 1, 5'd7, 16'h5678, 2'd2);
    step();

    // Duplicate tag in way3: lowest matching index wins
    drive(0, 1, 2'd1, 2'd3, 5'd7, 16'h9999, 1);
    expect_rsp("dup_fill", M_WAY, 0, 0, 0, 0, 0, 2'd3);
    step();
    drive(1, 0, 2'd1, 2'd0, 5'd7, 16'h0, 0);
    expect_rsp("dup_hit", M_HIT|M_WAY|M_DAT, 1, 0, 0, 0, 16'h5678, 2'd2);
    step();
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
